// File: rtl/fp_align_stage.sv
// fp_align_stage
//   Exponent-alignment stage of the single-precision FP adder. Accepts a
//   magnitude-ordered operand pair, restores hidden bits, and right-shifts the
//   smaller significand by the exponent difference a few bits per cycle.
//   Bits shifted past the LSB collapse into a sticky bit. The aligned operands
//   are then held for the add/normalise stage until it accepts them.
//
// Parameters
//   STEP         bits shifted per SHIFT cycle (1, 2 or 4)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     largereg/smallreg valid
//   in_ready     stage idle and able to capture an operand pair
//   largereg     larger-magnitude IEEE-754 single operand
//   smallreg     smaller-magnitude IEEE-754 single operand
//   out_valid    aligned result valid (held until out_ready)
//   out_ready    downstream accepts the result
//   out_exp      common (effective) exponent of largereg
//   out_mant_l   {hidden, mantissa} of largereg
//   out_mant_s   {hidden, mantissa, G, R, S} of smallreg after alignment
//   out_sign_l   sign of largereg
//   out_sign_s   sign of smallreg
//   out_eff_sub  signs differ, so the adder must subtract
//   out_special  an exponent is all ones (Inf/NaN); operands passed unshifted
module fp_align_stage #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] largereg,
    input  logic [31:0] smallreg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_exp,
    output logic [23:0] out_mant_l,
    output logic [26:0] out_mant_s,
    output logic        out_sign_l,
    output logic        out_sign_s,
    output logic        out_eff_sub,
    output logic        out_special
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [4:0] STEP_K  = 5'(STEP);
    // 27 shifts push every significand and guard bit into sticky.
    localparam logic [4:0] MAX_CNT = 5'd27;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  exp_q, exp_d;
    logic [23:0] mant_l_q, mant_l_d;
    logic [26:0] mant_s_q, mant_s_d;
    logic        sign_l_q, sign_l_d;
    logic        sign_s_q, sign_s_d;
    logic        special_q, special_d;

    logic [7:0]  exp_l_raw, exp_s_raw;
    logic [7:0]  eff_l, eff_s, diff;
    logic        hid_l, hid_s;
    logic        special_in;
    logic [4:0]  cnt_in;
    logic [4:0]  step_k;

    // Right shift by k (k <= 4) one bit at a time; each bit leaving position 0
    // is folded into the new position 0 so the sticky bit accumulates.
    function automatic logic [26:0] shift_sticky(input logic [26:0] m,
                                                 input logic [4:0]  k);
        logic [26:0] r;
        r = m;
        for (int i = 0; i < 4; i++) begin
            if (5'(i) < k) begin
                r = {1'b0, r[26:2], r[1] | r[0]};
            end
        end
        return r;
    endfunction

    always_comb begin
        exp_l_raw  = largereg[30:23];
        exp_s_raw  = smallreg[30:23];
        // Denormals use exponent 1 with a zero hidden bit.
        hid_l      = (exp_l_raw != 8'd0);
        hid_s      = (exp_s_raw != 8'd0);
        eff_l      = hid_l ? exp_l_raw : 8'd1;
        eff_s      = hid_s ? exp_s_raw : 8'd1;
        diff       = eff_l - eff_s;
        cnt_in     = (diff > 8'd27) ? MAX_CNT : diff[4:0];
        special_in = (exp_l_raw == 8'hFF) | (exp_s_raw == 8'hFF);
        // Final SHIFT cycle may need fewer than STEP bits.
        step_k     = (cnt_q < STEP_K) ? cnt_q : STEP_K;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        mant_l_d  = mant_l_q;
        mant_s_d  = mant_s_q;
        sign_l_d  = sign_l_q;
        sign_s_d  = sign_s_q;
        special_d = special_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_d     = eff_l;
                    mant_l_d  = {hid_l, largereg[22:0]};
                    mant_s_d  = {hid_s, smallreg[22:0], 3'b000};
                    sign_l_d  = largereg[31];
                    sign_s_d  = smallreg[31];
                    special_d = special_in;
                    cnt_d     = cnt_in;
                    state_d   = (special_in || cnt_in == 5'd0) ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                mant_s_d = shift_sticky(mant_s_q, step_k);
                cnt_d    = cnt_q - step_k;
                if (cnt_q == step_k) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            exp_q     <= 8'd0;
            mant_l_q  <= 24'd0;
            mant_s_q  <= 27'd0;
            sign_l_q  <= 1'b0;
            sign_s_q  <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            mant_l_q  <= mant_l_d;
            mant_s_q  <= mant_s_d;
            sign_l_q  <= sign_l_d;
            sign_s_q  <= sign_s_d;
            special_q <= special_d;
        end
    end

    assign in_ready    = (state_q == IDLE) & ~rst;
    assign out_valid   = (state_q == HOLD);
    assign out_exp     = exp_q;
    assign out_mant_l  = mant_l_q;
    assign out_mant_s  = mant_s_q;
    assign out_sign_l  = sign_l_q;
    assign out_sign_s  = sign_s_q;
    assign out_eff_sub = sign_l_q ^ sign_s_q;
    assign out_special = special_q;

endmodule
